dck_loader: RTL and testbench



---
 rtl/dck_loader_pkg.sv | 30 +++
 rtl/dck_loader_if.sv | 25 ++
 rtl/dck_loader.sv | 218 +++++++++++++++++++++
 tb/tb_dck_loader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dck_loader_pkg.sv
// Shared types and constants for the Timex DCK cartridge loader.
// Holds the parser state enum, bank id/code constants and the present-chunk search helper.
package ts2068_dck_pkg;

    typedef enum logic [2:0] {IDLE, HDR, DATA, SKIP, DONE} dckState_t;

    localparam logic [7:0] BID_DOCK  = 8'h00;
    localparam logic [7:0] BID_EXROM = 8'hFE;
    localparam logic [7:0] BID_HOME  = 8'hFF;

    localparam logic [1:0] BANK_DOCK  = 2'd0;
    localparam logic [1:0] BANK_EXROM = 2'd1;
    localparam logic [1:0] BANK_HOME  = 2'd2;

    localparam int unsigned CHUNK_SIZE = 8192;
    localparam logic [12:0] OFFSET_LAST = 13'(CHUNK_SIZE - 1);

    // Lowest set bit of mask at or above index 'from'; result is {found, index}.
    function automatic logic [3:0] nextPresent(input logic [7:0] mask, input logic [3:0] from);
        logic [3:0] res;
        res = 4'b0;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (4'(i) >= from)) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/dck_loader_if.sv
// Download byte stream in, linear memory write strobe out.
// The dioS file-size field exists only when DCK_SIZECHK_EN is defined.
interface dck_loader_if #(
    parameter int unsigned AW = 18
);
    logic          dckE;
    logic [26:0]   dioA;
    logic [7:0]    dioD;
    logic          dioW;
`ifdef DCK_SIZECHK_EN
    logic [31:0]   dioS;
`endif
    logic [AW-1:0] memA;
    logic [7:0]    memD;
    logic          memW;

`ifdef DCK_SIZECHK_EN
    modport master (output dckE, dioA, dioD, dioW, dioS, input memA, memD, memW);
    modport slave  (input dckE, dioA, dioD, dioW, dioS, output memA, memD, memW);
`else
    modport master (output dckE, dioA, dioD, dioW, input memA, memD, memW);
    modport slave  (input dckE, dioA, dioD, dioW, output memA, memD, memW);
`endif

endinterface

// File: rtl/dck_loader.sv
// Timex DCK container parser: turns the download byte stream into cartridge memory writes
// and per-bank chunk ROM/present maps. DCK_SIZECHK_EN adds a file-size check at end of download.
module dck_loader
    import ts2068_dck_pkg::*;
#(
    parameter int unsigned MAXBLK = 3,
    parameter int unsigned AW     = 18
) (
    input  logic       clock,
    input  logic       reset,
    dck_loader_if.slave dio,
    output logic [7:0] dockRom,
    output logic [7:0] dockPre,
    output logic [7:0] exrmRom,
    output logic [7:0] exrmPre,
    output logic [7:0] homeRom,
    output logic [7:0] homePre,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned BCW = $clog2(MAXBLK + 1);

    dckState_t       stateQ, stateD;
    logic            dckEQ;
    logic [26:0]     byteCntQ, byteCntD;
    logic [3:0]      hdrIdxQ, hdrIdxD;
    logic [1:0]      bankQ, bankD;
    logic [2:0]      chunkQ, chunkD;
    logic [12:0]     offsetQ, offsetD;
    logic [BCW-1:0]  blkCntQ, blkCntD;
    logic [7:0]      curPreQ, curPreD;
    logic [2:0][7:0] romQ, romD, preQ, preD;
    logic            busyQ, busyD, doneQ, doneD, errorQ, errorD;
    logic [AW-1:0]   memAQ, memAD;
    logic [7:0]      memDQ, memDD;
    logic            memWQ, memWD;
    logic            sizeOk;
    logic [3:0]      nxt;
    logic [2:0]      slot;

`ifdef DCK_SIZECHK_EN
    assign sizeOk = (dio.dioS[31:27] == 5'd0) && (byteCntQ == dio.dioS[26:0]);
`else
    assign sizeOk = 1'b1;
`endif

    always_comb begin
        stateD   = stateQ;
        byteCntD = byteCntQ;
        hdrIdxD  = hdrIdxQ;
        bankD    = bankQ;
        chunkD   = chunkQ;
        offsetD  = offsetQ;
        blkCntD  = blkCntQ;
        curPreD  = curPreQ;
        romD     = romQ;
        preD     = preQ;
        busyD    = busyQ;
        doneD    = doneQ;
        errorD   = errorQ;
        memAD    = memAQ;
        memDD    = memDQ;
        memWD    = 1'b0;
        nxt      = 4'b0;
        slot     = 3'(hdrIdxQ - 4'd1);

        // Rising edge restarts the parser; a byte in the same cycle is handled below as byte 0.
        if (dio.dckE && !dckEQ) begin
            romD     = '0;
            preD     = '0;
            doneD    = 1'b0;
            errorD   = 1'b0;
            busyD    = 1'b1;
            byteCntD = '0;
            blkCntD  = '0;
            hdrIdxD  = '0;
            curPreD  = '0;
            stateD   = HDR;
        end

        if (!dio.dckE && dckEQ) begin
            busyD  = 1'b0;
            stateD = IDLE;
            if (stateQ == HDR && hdrIdxQ == 4'd0 && blkCntQ != '0 && sizeOk) begin
                doneD = 1'b1;
            end else begin
                doneD  = 1'b0;
                errorD = 1'b1;
            end
        end else if (dio.dckE && dio.dioW) begin
            if (stateD == SKIP) begin
                byteCntD = byteCntD + 27'd1;
            end else if (stateD == HDR || stateD == DATA) begin
                if (dio.dioA != byteCntD) begin
                    errorD = 1'b1;
                    stateD = SKIP;
                end else begin
                    byteCntD = byteCntD + 27'd1;
                    if (stateD == HDR) begin
                        if (hdrIdxD == 4'd0) begin
                            curPreD = '0;
                            hdrIdxD = 4'd1;
                            if (blkCntD == BCW'(MAXBLK)) begin
                                errorD = 1'b1;
                                stateD = SKIP;
                            end else begin
                                case (dio.dioD)
                                    BID_DOCK:  bankD = BANK_DOCK;
                                    BID_EXROM: bankD = BANK_EXROM;
                                    BID_HOME:  bankD = BANK_HOME;
                                    default: begin
                                        errorD = 1'b1;
                                        stateD = SKIP;
                                    end
                                endcase
                            end
                        end else if (dio.dioD > 8'd3) begin
                            errorD = 1'b1;
                            stateD = SKIP;
                        end else begin
                            slot                = 3'(hdrIdxD - 4'd1);
                            romD[bankD][slot]   = dio.dioD[1];
                            preD[bankD][slot]   = dio.dioD[0];
                            curPreD[slot]       = dio.dioD[0];
                            if (hdrIdxD == 4'd8) begin
                                nxt     = nextPresent(curPreD, 4'd0);
                                hdrIdxD = 4'd0;
                                if (nxt[3]) begin
                                    chunkD  = nxt[2:0];
                                    offsetD = '0;
                                    stateD  = DATA;
                                end else begin
                                    blkCntD = blkCntD + BCW'(1);
                                end
                            end else begin
                                hdrIdxD = hdrIdxD + 4'd1;
                            end
                        end
                    end else begin
                        memAD = AW'({bankD, chunkD, offsetD});
                        memDD = dio.dioD;
                        memWD = 1'b1;
                        if (offsetD == OFFSET_LAST) begin
                            nxt     = nextPresent(curPreD, {1'b0, chunkD} + 4'd1);
                            offsetD = '0;
                            if (nxt[3]) begin
                                chunkD = nxt[2:0];
                            end else begin
                                blkCntD = blkCntD + BCW'(1);
                                hdrIdxD = 4'd0;
                                stateD  = HDR;
                            end
                        end else begin
                            offsetD = offsetD + 13'd1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateQ   <= IDLE;
            // Track the live level so a download already in progress is not re-entered.
            dckEQ    <= dio.dckE;
            byteCntQ <= '0;
            hdrIdxQ  <= '0;
            bankQ    <= '0;
            chunkQ   <= '0;
            offsetQ  <= '0;
            blkCntQ  <= '0;
            curPreQ  <= '0;
            romQ     <= '0;
            preQ     <= '0;
            busyQ    <= 1'b0;
            doneQ    <= 1'b0;
            errorQ   <= 1'b0;
            memAQ    <= '0;
            memDQ    <= '0;
            memWQ    <= 1'b0;
        end else begin
            stateQ   <= stateD;
            dckEQ    <= dio.dckE;
            byteCntQ <= byteCntD;
            hdrIdxQ  <= hdrIdxD;
            bankQ    <= bankD;
            chunkQ   <= chunkD;
            offsetQ  <= offsetD;
            blkCntQ  <= blkCntD;
            curPreQ  <= curPreD;
            romQ     <= romD;
            preQ     <= preD;
            busyQ    <= busyD;
            doneQ    <= doneD;
            errorQ   <= errorD;
            memAQ    <= memAD;
            memDQ    <= memDD;
            memWQ    <= memWD;
        end
    end

    assign dio.memA = memAQ;
    assign dio.memD = memDQ;
    assign dio.memW = memWQ;
    assign dockRom  = romQ[BANK_DOCK];
    assign dockPre  = preQ[BANK_DOCK];
    assign exrmRom  = romQ[BANK_EXROM];
    assign exrmPre  = preQ[BANK_EXROM];
    assign homeRom  = romQ[BANK_HOME];
    assign homePre  = preQ[BANK_HOME];
    assign busy     = busyQ;
    assign done     = doneQ;
    assign error    = errorQ;

endmodule

// File: tb/tb_dck_loader.sv
// Directed bench for dck_loader: scoreboarded memory writes plus map/status checks.
// Size-check cases run only when DCK_SIZECHK_EN is defined.
module tb_dck_loader;
    import ts2068_dck_pkg::*;

    localparam int unsigned AW = 18;
    typedef logic [AW+7:0] wr_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dck_loader_if #(.AW(AW)) dif ();

    logic [7:0] dockRom, dockPre, exrmRom, exrmPre, homeRom, homePre;
    logic       busy, done, error;

    dck_loader #(.MAXBLK(3), .AW(AW)) dut (
        .clock   (clock),
        .reset   (reset),
        .dio     (dif),
        .dockRom (dockRom),
        .dockPre (dockPre),
        .exrmRom (exrmRom),
        .exrmPre (exrmPre),
        .homeRom (homeRom),
        .homePre (homePre),
        .busy    (busy),
        .done    (done),
        .error   (error)
    );

    int          nChecks = 0;
    int          nErrors = 0;
    wr_t         expQ[$];
    wr_t         obsQ[$];
    logic [26:0] fa;

    always @(negedge clock) begin
        if (dif.memW === 1'b1) obsQ.push_back({dif.memA, dif.memD});
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nErrors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sendByte(input logic [7:0] d);
        @(posedge clock);
        #1;
        dif.dckE = 1'b1;
        dif.dioA = fa;
        dif.dioD = d;
        dif.dioW = 1'b1;
        fa = fa + 27'd1;
    endtask

    task automatic sendHdr(input logic [71:0] h);
        for (int i = 0; i < 9; i++) sendByte(h[71-8*i -: 8]);
    endtask

    task automatic sendChunk(input logic [1:0] b, input logic [2:0] c, input int n);
        for (int i = 0; i < n; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            expQ.push_back({b, c, 13'(i), d});
            sendByte(d);
        end
    endtask

    task automatic sendSkip(input int n);
        for (int i = 0; i < n; i++) sendByte(8'($urandom));
    endtask

    task automatic quiet();
        @(posedge clock);
        #1;
        dif.dioW = 1'b0;
        @(negedge clock);
    endtask

    task automatic endDl();
        @(posedge clock);
        #1;
        dif.dioW = 1'b0;
        dif.dckE = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkWrites(input string tag);
        int e0;
        check({tag, "/count"}, 32'(obsQ.size()), 32'(expQ.size()));
        e0 = nErrors;
        while (obsQ.size() > 0 && expQ.size() > 0) begin
            wr_t o, e;
            o = obsQ.pop_front();
            e = expQ.pop_front();
            check({tag, "/write"}, 32'(o), 32'(e));
            if (nErrors != e0) break;
        end
        obsQ.delete();
        expQ.delete();
    endtask

    task automatic checkStatus(input string tag, input logic b, input logic d, input logic e);
        check({tag, "/status"}, {29'd0, busy, done, error}, {29'd0, b, d, e});
    endtask

    initial begin
        dif.dckE = 1'b0;
        dif.dioA = '0;
        dif.dioD = '0;
        dif.dioW = 1'b0;
`ifdef DCK_SIZECHK_EN
        dif.dioS = '0;
`endif
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("rst/maps1", {dockRom, dockPre, exrmRom, exrmPre}, 32'h0);
        check("rst/maps2", {16'h0, homeRom, homePre}, 32'h0);
        check("rst/mem", {5'd0, dif.memW, dif.memD, dif.memA}, 32'h0);
        checkStatus("rst", 1'b0, 1'b0, 1'b0);

        // Single DOCK chunk; first header byte arrives on the dckE rising edge.
        fa = '0;
`ifdef DCK_SIZECHK_EN
        dif.dioS = 32'd8201;
`endif
        sendHdr(72'h00_03_00_00_00_00_00_00_00);
        quiet();
        checkStatus("t1/busy", 1'b1, 1'b0, 1'b0);
        sendChunk(2'd0, 3'd0, 8192);
        endDl();
        checkWrites("t1");
        check("t1/dock", {16'h0, dockRom, dockPre}, 32'h0101);
        checkStatus("t1", 1'b0, 1'b1, 1'b0);

        // Two blocks: DOCK chunks 0 and 7, then EXROM chunk 1.
        fa = '0;
`ifdef DCK_SIZECHK_EN
        dif.dioS = 32'd24594;
`endif
        sendHdr(72'h00_03_00_00_00_00_00_00_03);
        sendChunk(2'd0, 3'd0, 8192);
        sendChunk(2'd0, 3'd7, 8192);
        sendHdr(72'hFE_02_03_00_00_00_00_00_00);
        sendChunk(2'd1, 3'd1, 8192);
        endDl();
        checkWrites("t2");
        check("t2/maps", {dockRom, dockPre, exrmRom, exrmPre}, 32'h8181_0302);
        check("t2/home", {16'h0, homeRom, homePre}, 32'h0);
        checkStatus("t2", 1'b0, 1'b1, 1'b0);

        // Bad bank id.
        fa = '0;
        sendHdr(72'h42_03_00_00_00_00_00_00_00);
        quiet();
        checkStatus("t3/mid", 1'b1, 1'b0, 1'b1);
        sendSkip(40);
        endDl();
        checkWrites("t3");
        checkStatus("t3", 1'b0, 1'b0, 1'b1);

        // Truncated chunk: partial writes land, maps stay visible.
        fa = '0;
        sendHdr(72'h00_01_00_00_00_00_00_00_00);
        sendChunk(2'd0, 3'd0, 100);
        endDl();
        checkWrites("t4");
        check("t4/dock", {16'h0, dockRom, dockPre}, 32'h0001);
        checkStatus("t4", 1'b0, 1'b0, 1'b1);

        // Reset mid-chunk, then bytes with dckE still high are ignored.
        fa = '0;
        sendHdr(72'h00_01_00_00_00_00_00_00_00);
        sendChunk(2'd0, 3'd0, 50);
        @(posedge clock);
        #1;
        dif.dioW = 1'b0;
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        check("t5/maps", {dockRom, dockPre, exrmRom, exrmPre}, 32'h0);
        check("t5/mem", {5'd0, dif.memW, dif.memD, dif.memA}, 32'h0);
        checkStatus("t5/rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        sendSkip(20);
        quiet();
        repeat (2) @(negedge clock);
        checkWrites("t5");
        checkStatus("t5/after", 1'b0, 1'b0, 1'b0);
        endDl();

        // Download with zero blocks.
        fa = '0;
        @(posedge clock);
        #1 dif.dckE = 1'b1;
        endDl();
        checkStatus("t6", 1'b0, 1'b0, 1'b1);

        // MAXBLK empty blocks are fine; one more header byte is an error.
        fa = '0;
        for (int i = 0; i < 3; i++) sendHdr(72'h0);
        quiet();
        checkStatus("t7/max", 1'b1, 1'b0, 1'b0);
        sendByte(8'h00);
        quiet();
        checkStatus("t7/over", 1'b1, 1'b0, 1'b1);
        endDl();
        checkStatus("t7", 1'b0, 1'b0, 1'b1);

        // dioA jumps from 10 to 12.
        fa = '0;
        sendHdr(72'h00_01_00_00_00_00_00_00_00);
        sendChunk(2'd0, 3'd0, 2);
        fa = 27'd12;
        sendSkip(11);
        quiet();
        checkStatus("t8/mid", 1'b1, 1'b0, 1'b1);
        endDl();
        checkWrites("t8");
        checkStatus("t8", 1'b0, 1'b0, 1'b1);

        // New download clears error on the rising edge and reloads.
        fa = '0;
`ifdef DCK_SIZECHK_EN
        dif.dioS = 32'd9;
`endif
        sendByte(8'h00);
        quiet();
        checkStatus("t9/rise", 1'b1, 1'b0, 1'b0);
        sendByte(8'h02);
        for (int i = 0; i < 7; i++) sendByte(8'h00);
        endDl();
        checkWrites("t9");
        check("t9/dock", {16'h0, dockRom, dockPre}, 32'h0100);
        checkStatus("t9", 1'b0, 1'b1, 1'b0);

`ifdef DCK_SIZECHK_EN
        fa = '0;
        dif.dioS = 32'd10;
        sendHdr(72'h0);
        endDl();
        checkStatus("t10/bad", 1'b0, 1'b0, 1'b1);
        fa = '0;
        dif.dioS = 32'd9;
        sendHdr(72'h0);
        endDl();
        checkStatus("t10/good", 1'b0, 1'b1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
